// File: rtl/fp_au_pkg.sv
// Shared definitions for the arithmetic-unit floating-point paths.
// Holds the IEEE-754 single-precision field widths, the exponent bias,
// the canonical quiet-NaN and +infinity encodings, the sequencer state
// enum and the operand class enum. No ports.
package fp_au_pkg;

  localparam int          EXP_W   = 8;
  localparam int          MANT_W  = 23;
  localparam int          BIAS    = 127;
  localparam logic [31:0] QNAN    = 32'h7FC0_0000;
  localparam logic [31:0] POS_INF = 32'h7F80_0000;

  typedef enum logic [2:0] {
    IDLE,
    UNPACK,
    SPECIAL,
    DIVIDE,
    NORM,
    DONE
  } fp_state_t;

  typedef enum logic [1:0] {
    ZERO,
    NORMAL,
    INF,
    NAN
  } fp_class_t;

endpackage

// File: rtl/fp_classify.sv
// Combinational IEEE-754 operand splitter and classifier.
// Denormals are flushed to zero, so any operand with a zero exponent is
// reported as ZERO with a cleared significand.
//
// Ports:
//   op_i    in   packed floating-point operand
//   sign_o  out  sign bit
//   exp_o   out  biased exponent field
//   sig_o   out  significand with the hidden bit restored (0 unless NORMAL)
//   class_o out  operand class, encoded as fp_class_t
module fp_classify #(
  parameter int EXP_W  = fp_au_pkg::EXP_W,
  parameter int MANT_W = fp_au_pkg::MANT_W
) (
  input  logic [EXP_W+MANT_W:0] op_i,
  output logic                  sign_o,
  output logic [EXP_W-1:0]      exp_o,
  output logic [MANT_W:0]       sig_o,
  output logic [1:0]            class_o
);
  import fp_au_pkg::*;

  logic [MANT_W-1:0] frac;

  assign sign_o = op_i[EXP_W+MANT_W];
  assign exp_o  = op_i[EXP_W+MANT_W-1 -: EXP_W];
  assign frac   = op_i[MANT_W-1:0];

  // NOTE: every output of a combinational block gets a default before any
  // branch; a path that leaves one unassigned would infer a latch.
  always_comb begin
    class_o = NORMAL;
    sig_o   = {1'b1, frac};
    if (exp_o == '0) begin
      class_o = ZERO;
      sig_o   = '0;
    end else if (&exp_o) begin
      class_o = (frac != '0) ? NAN : INF;
      sig_o   = '0;
    end
  end

endmodule

// File: rtl/fp_div_seq.sv
// Iterative IEEE-754 single-precision divider, one quotient bit per cycle,
// with valid/ready handshakes on request and response.
//
// Optional build macro FP_DIV_ROUND_NEAREST_EN: when defined, NORM rounds to
// nearest-even using guard, round and sticky; otherwise the quotient is
// truncated toward zero.
//
// Ports:
//   clk, rst_n  rising-edge clock, asynchronous active-low reset
//   in_valid    request valid          in_ready  divider idle, can accept
//   a, b        dividend, divisor      busy      any state except IDLE
//   out_valid   result valid           out_ready consumer takes the result
//   result      quotient               overflag  overflow, result is +/-inf
//   underflag   underflow, result is +/-0
module fp_div_seq #(
  parameter int EXP_W  = fp_au_pkg::EXP_W,
  parameter int MANT_W = fp_au_pkg::MANT_W,
  parameter int ITER   = MANT_W + 3
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [EXP_W+MANT_W:0] a,
  input  logic [EXP_W+MANT_W:0] b,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [EXP_W+MANT_W:0] result,
  output logic                  overflag,
  output logic                  underflag,
  output logic                  busy
);
  import fp_au_pkg::*;

  localparam int W       = EXP_W + MANT_W + 1;
  localparam int SIG_W   = MANT_W + 1;
  localparam int EXP_X_W = EXP_W + 2;
  localparam int CNT_W   = $clog2(ITER + 1);
  localparam logic signed [EXP_X_W-1:0] BIAS_X  = EXP_X_W'(BIAS);
  localparam logic signed [EXP_X_W-1:0] EXP_MAX = EXP_X_W'((1 << EXP_W) - 1);
  localparam logic signed [EXP_X_W-1:0] ONE_X   = EXP_X_W'(1);

  fp_state_t                   state_q, state_d;
  logic [W-1:0]                a_q, a_d, b_q, b_d, res_q, res_d;
  logic                        sign_q, sign_d, sticky_q, sticky_d;
  logic                        over_q, over_d, under_q, under_d;
  logic signed [EXP_X_W-1:0]   exp_q, exp_d;
  logic [SIG_W-1:0]            div_q, div_d;
  logic [SIG_W:0]              rem_q, rem_d;
  logic [ITER-1:0]             quo_q, quo_d;
  logic [CNT_W-1:0]            cnt_q, cnt_d;

  logic                        sign_a, sign_b;
  logic [EXP_W-1:0]            exp_a, exp_b;
  logic [SIG_W-1:0]            sig_a, sig_b;
  logic [1:0]                  cls_a, cls_b;

  fp_classify #(.EXP_W(EXP_W), .MANT_W(MANT_W)) u_cls_a (
    .op_i(a_q), .sign_o(sign_a), .exp_o(exp_a), .sig_o(sig_a), .class_o(cls_a)
  );
  fp_classify #(.EXP_W(EXP_W), .MANT_W(MANT_W)) u_cls_b (
    .op_i(b_q), .sign_o(sign_b), .exp_o(exp_b), .sig_o(sig_b), .class_o(cls_b)
  );

  // Special-operand decode, listed in priority order.
  logic sign_x, spec_nan, spec_inf, spec_zero;
  assign sign_x    = sign_a ^ sign_b;
  assign spec_nan  = (cls_a == NAN) || (cls_b == NAN) ||
                     (cls_a == ZERO && cls_b == ZERO) ||
                     (cls_a == INF && cls_b == INF);
  assign spec_inf  = (cls_a == INF) || (cls_b == ZERO);
  assign spec_zero = (cls_a == ZERO) || (cls_b == INF);

  // Restoring step: subtract the divisor when it fits, then shift.
  logic [SIG_W:0] rem_nxt;
  logic           q_bit;
  assign q_bit   = rem_q >= {1'b0, div_q};
  assign rem_nxt = q_bit ? (rem_q - {1'b0, div_q}) : rem_q;

  // Normalisation. The quotient lies in (0.5, 2), so at most one left shift
  // brings the leading one to the top; the two bits below the 24-bit
  // significand are then guard and round.
  logic [ITER-1:0]           quo_n;
  logic signed [EXP_X_W-1:0] exp_n, exp_f;
  logic [SIG_W-1:0]          mant_t, mant_f;
  logic [W-1:0]              norm_res;
  logic                      norm_over, norm_under, unused_norm;

  assign quo_n  = quo_q[ITER-1] ? quo_q : {quo_q[ITER-2:0], 1'b0};
  assign exp_n  = quo_q[ITER-1] ? exp_q : exp_q - ONE_X;
  assign mant_t = quo_n[ITER-1 -: SIG_W];

`ifdef FP_DIV_ROUND_NEAREST_EN
  logic           round_up;
  logic [SIG_W:0] mant_r;
  assign round_up = quo_n[1] & (quo_n[0] | sticky_q | mant_t[0]);
  assign mant_r   = {1'b0, mant_t} + {{SIG_W{1'b0}}, round_up};
  // A carry out only happens from all-ones, so the shifted value is exact.
  assign mant_f   = mant_r[SIG_W] ? mant_r[SIG_W:1] : mant_r[SIG_W-1:0];
  assign exp_f    = mant_r[SIG_W] ? exp_n + ONE_X : exp_n;
  assign unused_norm = ^{mant_f[SIG_W-1], rem_nxt[SIG_W]};
`else
  assign mant_f   = mant_t;
  assign exp_f    = exp_n;
  assign unused_norm = ^{mant_f[SIG_W-1], quo_n[1:0], sticky_q, rem_nxt[SIG_W]};
`endif

  always_comb begin
    norm_over  = 1'b0;
    norm_under = 1'b0;
    norm_res   = {sign_q, exp_f[EXP_W-1:0], mant_f[MANT_W-1:0]};
    if (exp_f >= EXP_MAX) begin
      norm_over = 1'b1;
      norm_res  = {sign_q, {EXP_W{1'b1}}, {MANT_W{1'b0}}};
    end else if (exp_f < ONE_X) begin
      norm_under = 1'b1;
      norm_res   = {sign_q, {(W-1){1'b0}}};
    end
  end

  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    res_d    = res_q;
    sign_d   = sign_q;
    exp_d    = exp_q;
    div_d    = div_q;
    rem_d    = rem_q;
    quo_d    = quo_q;
    cnt_d    = cnt_q;
    sticky_d = sticky_q;
    over_d   = over_q;
    under_d  = under_q;
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_d     = a;
          b_d     = b;
          state_d = UNPACK;
        end
      end
      UNPACK: begin
        sign_d   = sign_x;
        exp_d    = $signed({2'b00, exp_a}) - $signed({2'b00, exp_b}) + BIAS_X;
        div_d    = sig_b;
        rem_d    = {1'b0, sig_a};
        quo_d    = '0;
        cnt_d    = '0;
        sticky_d = 1'b0;
        state_d  = DIVIDE;
        if (spec_nan) begin
          res_d   = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MANT_W-1){1'b0}}};
          state_d = SPECIAL;
        end else if (spec_inf) begin
          res_d   = {sign_x, {EXP_W{1'b1}}, {MANT_W{1'b0}}};
          state_d = SPECIAL;
        end else if (spec_zero) begin
          res_d   = {sign_x, {(W-1){1'b0}}};
          state_d = SPECIAL;
        end
      end
      SPECIAL: state_d = DONE;
      DIVIDE: begin
        // ITER cycles each retire one quotient bit; the extra closing cycle
        // folds the final remainder into the sticky bit.
        if (cnt_q == CNT_W'(ITER)) begin
          sticky_d = |rem_q;
          state_d  = NORM;
        end else begin
          rem_d = {rem_nxt[SIG_W-1:0], 1'b0};
          quo_d = {quo_q[ITER-2:0], q_bit};
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      NORM: begin
        res_d   = norm_res;
        over_d  = norm_over;
        under_d = norm_under;
        state_d = DONE;
      end
      DONE: begin
        if (out_ready) begin
          over_d  = 1'b0;
          under_d = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every register
  // samples the pre-edge values, regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      a_q      <= '0;
      b_q      <= '0;
      res_q    <= '0;
      sign_q   <= 1'b0;
      exp_q    <= '0;
      div_q    <= '0;
      rem_q    <= '0;
      quo_q    <= '0;
      cnt_q    <= '0;
      sticky_q <= 1'b0;
      over_q   <= 1'b0;
      under_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      res_q    <= res_d;
      sign_q   <= sign_d;
      exp_q    <= exp_d;
      div_q    <= div_d;
      rem_q    <= rem_d;
      quo_q    <= quo_d;
      cnt_q    <= cnt_d;
      sticky_q <= sticky_d;
      over_q   <= over_d;
      under_q  <= under_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign busy      = (state_q != IDLE);
  assign out_valid = (state_q == DONE);
  assign result    = res_q;
  assign overflag  = over_q;
  assign underflag = under_q;

endmodule

// File: doc/fp_div_seq.md
Name: fp_div_seq

Overview:
- Iterative IEEE-754 single-precision divider with valid/ready request and response handshakes.
- Responder for AU divide requests: the requester presents A, B and waits for a result, as the AU harness does for sel=11.
- Returns result plus overflag/underflag with the AU flag semantics.
- Trades the combinational divider's area for a fixed multi-cycle latency.

Parameters:
- EXP_W, 8, exponent width
- MANT_W, 23, stored fraction width
- ITER, MANT_W+3, quotient bits produced: 24 significand + guard + round

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- in_valid  in  1  request valid
- in_ready  out  1  divider can accept a request
- a  in  32  dividend, IEEE-754 single
- b  in  32  divisor, IEEE-754 single
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts result
- result  out  32  quotient
- overflag  out  1  exponent overflow; result is ±inf
- underflag  out  1  exponent underflow; result is ±0
- busy  out  1  high in every state except IDLE

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE; in_ready=1.
  - out_valid=0, result=0, overflag=0, underflag=0, busy=0.
  - Iteration counter and working registers cleared.
  - Reset mid-operation abandons the request; no output is produced.
- in_ready=1 only in IDLE. A request is accepted on an edge where in_valid&in_ready; a and b are latched on that edge.
- FSM: IDLE -> UNPACK -> (SPECIAL -> DONE) | (DIVIDE -> NORM -> DONE) -> IDLE.
- UNPACK, one cycle:
  - Classify a and b. Denormals flush to zero.
  - sign = sa^sb; exp_tmp = ea - eb + 127, signed 10-bit.
- Specials, checked in priority order; each goes straight to DONE:
  - Any NaN, 0/0, or inf/inf -> 0x7FC00000, flags 0.
  - inf/x or x/0 -> {sign, 0xFF, 0}, flags 0.
  - 0/x or x/inf -> {sign, 0, 0}, flags 0.
- DIVIDE:
  - Restoring division of {1,ma} by {1,mb}, one quotient bit per cycle, exactly ITER cycles.
  - Remainder is 25 bits. A sticky bit is formed from the final remainder != 0.
- NORM, one cycle:
  - If the quotient MSB is 0: shift left 1, exp_tmp -= 1.
  - Truncate to 23 fraction bits (round-toward-zero).
  - exp_tmp >= 255 -> overflag=1, result {sign, 0xFF, 0}.
  - exp_tmp <= 0 -> underflag=1, result {sign, 0, 0}.
- Latency:
  - Normal operands: out_valid rises 29 edges after the accept edge (1 UNPACK + 26 DIVIDE + 1 NORM + 1).
  - Specials: out_valid rises 2 edges after the accept edge.
- DONE:
  - out_valid=1; result and flags held stable until an edge with out_ready=1, then IDLE.
  - in_ready stays 0 while out_valid is held.
  - No new request is accepted on the same edge that completes the handshake; in_ready rises the following cycle.
- Flags are valid only with out_valid. Both are cleared on leaving DONE.
- a/b changes while not in IDLE are ignored.

Optional Feature:
- Macro: FP_DIV_ROUND_NEAREST_EN.
- Defined: NORM applies round-to-nearest-even using guard, round and sticky.
  - Mantissa carry-out renormalises and increments the exponent.
  - The overflow check follows rounding.
  - NORM latency is unchanged (still one cycle).
- Undefined: truncation only; guard/round logic is absent.

Decomposition:
- Shared package fp_au_pkg:
  - constants EXP_W, MANT_W, BIAS=127, QNAN=32'h7FC00000, POS_INF=32'h7F800000;
  - fp_state_t enum {IDLE, UNPACK, SPECIAL, DIVIDE, NORM, DONE};
  - fp_class_t enum {ZERO, NORMAL, INF, NAN}.
- One sub-module, fp_classify: combinational sign/exp/mant split plus class. It is instantiated twice (a, b) and is reusable by the AU add/mul paths.

Test Plan:
- a=0x44FC6000 (2019), b=0xC4F9E000 (-1999), out_ready=1 -> result 0xBF8147D8, flags 0, out_valid 29 cycles after accept.
- 0x00000000/0x00000000 -> 0x7FC00000 after 2 cycles; 0xFF800000/0x7F800000 -> 0x7FC00000; 0x3F800000/0x00000000 -> 0x7F800000.
- 0x7F000000/0x00800000 -> overflag=1, result 0x7F800000; 0x00800000/0x7F000000 -> underflag=1, result 0x00000000.
- 0x3F800000/0x40400000 (1/3) -> 0x3EAAAAAA without the macro, 0x3EAAAAAB with FP_DIV_ROUND_NEAREST_EN.
- Back-pressure: hold out_ready=0 for 10 cycles after out_valid -> result stable, in_ready=0; a second in_valid is ignored until the handshake.
- Deassert rst_n at DIVIDE cycle 10 -> outputs at reset values immediately; after release, a new 2019/-1999 request completes correctly.
